// File: rtl/cache_pkg.sv
// cache_pkg: shared FSM state type and request-field/geometry helpers for assoc_cache.
package cache_pkg;
  typedef enum logic [1:0] {IDLE, LOOKUP, MEM, RESPOND} state_t;
  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction
  function automatic int tag_w(input int aw, input int sets);
    return aw - $clog2(sets);
  endfunction
  function automatic int wr_pos(input int aw, input int dw);
    return aw + dw;
  endfunction
  function automatic int data_lsb(input int aw);
    return aw;
  endfunction
endpackage

// File: rtl/cache_way.sv
// cache_way: one way of the set-associative cache (valid/tag/data per set, tag compare, fill and snoop invalidate).
module cache_way #(
  parameter int IDX_W  = 3,
  parameter int TAG_W  = 13,
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [IDX_W-1:0]  idx,
  input  logic [TAG_W-1:0]  tag,
  output logic              hit,
  output logic              valid,
  output logic [DATA_W-1:0] rdata,
  input  logic              we,
  input  logic [DATA_W-1:0] wdata,
  input  logic              inv,
  input  logic [IDX_W-1:0]  inv_idx,
  input  logic [TAG_W-1:0]  inv_tag
);
  localparam int SETS = 1 << IDX_W;
  logic [SETS-1:0] vld;
  logic [TAG_W-1:0] tags [SETS];
  logic [DATA_W-1:0] mem [SETS];
  // a same-cycle fill is matched against its incoming tag so the invalidate wins
  always_ff @(posedge clock or posedge reset)
    if (reset) vld <= '0;
    else begin
      if (we) vld[idx] <= 1'b1;
      if (inv && inv_tag == ((we && inv_idx == idx) ? tag : tags[inv_idx])) vld[inv_idx] <= 1'b0;
    end
  always_ff @(posedge clock)
    if (we) begin
      tags[idx] <= tag;
      mem[idx]  <= wdata;
    end
  assign valid = vld[idx];
  assign hit   = vld[idx] && tags[idx] == tag;
  assign rdata = mem[idx];
endmodule

// File: rtl/assoc_cache.sv
// assoc_cache: set-associative write-through cache with round-robin replacement and snoop invalidate.
// Define ASSOC_CACHE_STATS_EN to add saturating hit_count/miss_count outputs.
module assoc_cache import cache_pkg::*; #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int SETS   = 8,
  parameter int WAYS   = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [DATA_W+ADDR_W:0]   cpu_request,
  input  logic                     cpu_request_ready,
  input  logic [ADDR_W-1:0]        invalidate_address,
  input  logic                     invalidate_valid,
  input  logic [DATA_W-1:0]        memory_response,
  input  logic                     memory_response_ready,
  output logic [DATA_W+ADDR_W:0]   memory_request,
  output logic                     memory_request_ready,
  output logic [DATA_W-1:0]        data_out,
  output logic                     data_out_ready,
  output logic                     busy
`ifdef ASSOC_CACHE_STATS_EN
  ,
  output logic [15:0]              hit_count,
  output logic [15:0]              miss_count
`endif
);
  localparam int IDX_W  = idx_w(SETS);
  localparam int TAG_W  = tag_w(ADDR_W, SETS);
  localparam int WAY_W  = WAYS > 1 ? $clog2(WAYS) : 1;
  localparam int WR_POS = wr_pos(ADDR_W, DATA_W);
  localparam int D_LSB  = data_lsb(ADDR_W);
  state_t state;
  logic [DATA_W+ADDR_W:0] req_q;
  logic [WAY_W-1:0] rr [SETS];
  logic [WAY_W-1:0] way_q, hit_way, victim;
  logic hit_q, hit, fill;
  logic [WAYS-1:0] hit_v, vld_v;
  logic [DATA_W-1:0] rd [WAYS];
  logic [DATA_W-1:0] fill_data;
  wire wr = req_q[WR_POS];
  wire [ADDR_W-1:0] addr = req_q[ADDR_W-1:0];
  wire [IDX_W-1:0] idx = addr[IDX_W-1:0];
  assign hit       = |hit_v;
  assign fill      = state == MEM && memory_response_ready;
  assign fill_data = wr ? req_q[D_LSB +: DATA_W] : memory_response;
  for (genvar w = 0; w < WAYS; w++) begin : g_way
    cache_way #(.IDX_W(IDX_W), .TAG_W(TAG_W), .DATA_W(DATA_W)) u_way (
      .clock(clock), .reset(reset), .idx(idx), .tag(addr[ADDR_W-1:IDX_W]),
      .hit(hit_v[w]), .valid(vld_v[w]), .rdata(rd[w]),
      .we(fill && way_q == WAY_W'(w)), .wdata(fill_data),
      .inv(invalidate_valid), .inv_idx(invalidate_address[IDX_W-1:0]),
      .inv_tag(invalidate_address[ADDR_W-1:IDX_W]));
  end
  // downward scan leaves the lowest matching/invalid way selected
  always_comb begin
    hit_way = '0;
    victim  = rr[idx];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (hit_v[w]) hit_way = WAY_W'(w);
      if (!vld_v[w]) victim = WAY_W'(w);
    end
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state    <= IDLE;
      req_q    <= '0;
      way_q    <= '0;
      hit_q    <= 1'b0;
      data_out <= '0;
      for (int s = 0; s < SETS; s++) rr[s] <= '0;
    end else
      case (state)
        IDLE: if (cpu_request_ready) begin
          req_q <= cpu_request;
          state <= LOOKUP;
        end
        LOOKUP: begin
          hit_q <= hit;
          way_q <= hit ? hit_way : victim;
          if (hit && !wr) data_out <= rd[hit_way];
          state <= hit && !wr ? RESPOND : MEM;
        end
        MEM: if (memory_response_ready) begin
          data_out <= fill_data;
          state    <= RESPOND;
          if (!hit_q) rr[idx] <= rr[idx] == WAY_W'(WAYS - 1) ? '0 : rr[idx] + WAY_W'(1);
        end
        RESPOND: state <= IDLE;
        default: state <= IDLE;
      endcase
  assign memory_request       = req_q;
  assign memory_request_ready = state == MEM;
  assign data_out_ready       = state == RESPOND;
  assign busy                 = state != IDLE;
`ifdef ASSOC_CACHE_STATS_EN
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state == LOOKUP) begin
      if (hit && hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
      if (!hit && miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
    end
`endif
endmodule

// File: tb/tb_assoc_cache.sv
// tb_assoc_cache: scoreboard bench for assoc_cache (SETS=8, WAYS=2, 16-bit address/data).
module tb_assoc_cache;
  logic clock = 0, reset = 1;
  logic [32:0] cpu_request = '0;
  logic cpu_request_ready = 0;
  logic [15:0] invalidate_address = '0;
  logic invalidate_valid = 0;
  logic [15:0] memory_response = '0;
  logic memory_response_ready = 0;
  logic [32:0] memory_request;
  logic memory_request_ready, data_out_ready, busy;
  logic [15:0] data_out;
`ifdef ASSOC_CACHE_STATS_EN
  logic [15:0] hit_count, miss_count;
`endif
  int n_checks = 0, n_fail = 0, exp_hits = 0, exp_misses = 0;
  logic [15:0] exp_q [$];

  always #5 clock = ~clock;

  assoc_cache dut (
    .clock(clock), .reset(reset),
    .cpu_request(cpu_request), .cpu_request_ready(cpu_request_ready),
    .invalidate_address(invalidate_address), .invalidate_valid(invalidate_valid),
    .memory_response(memory_response), .memory_response_ready(memory_response_ready),
    .memory_request(memory_request), .memory_request_ready(memory_request_ready),
    .data_out(data_out), .data_out_ready(data_out_ready), .busy(busy)
`ifdef ASSOC_CACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clock)
    if (data_out_ready) begin
      if (exp_q.size() == 0) check("spurious_dout", 1, 0);
      else check("data_out", data_out, exp_q.pop_front());
    end

  // x is the memory fill data on a miss, or the expected cached data on a read hit
  task automatic txn(input logic wr, input logic [15:0] a, input logic [15:0] d, input bit hit,
                     input logic [15:0] x, input int dly, input bit inv);
    bit need_mem, seen, done;
    int cyc, wait_cyc;
    need_mem = !hit || wr;
    seen = 0; done = 0; cyc = 0; wait_cyc = 0;
    exp_q.push_back(wr ? d : x);
    if (hit) exp_hits++; else exp_misses++;
    @(negedge clock);
    cpu_request = {wr, d, a};
    cpu_request_ready = 1;
    while (!done && cyc < 40) begin
      @(posedge clock);
      cyc++;
      @(negedge clock);
      memory_response_ready = 0;
      invalidate_valid = 0;
      if (memory_request_ready) begin
        if (!seen) begin
          seen = 1;
          if (!need_mem) check("unexpected_mem", 1, 0);
          else begin
            check("mem_req_lat", cyc, 2);
            check("mem_req", wr ? memory_request : {memory_request[32], 16'h0, memory_request[15:0]},
                  {wr, wr ? d : 16'h0, a});
          end
        end
        if (wait_cyc == dly) begin
          memory_response = wr ? 16'hBEEF : x;
          memory_response_ready = 1;
          if (inv) begin
            invalidate_address = a;
            invalidate_valid = 1;
          end
        end
        wait_cyc++;
      end
      if (data_out_ready) begin
        cpu_request_ready = 0;
        done = 1;
      end
    end
    check("done", done, 1);
    check("latency", cyc, need_mem ? 3 + dly : 2);
    check("mem_seen", seen, need_mem);
  endtask

  task automatic inv_pulse(input logic [15:0] a);
    @(negedge clock);
    invalidate_address = a;
    invalidate_valid = 1;
    @(negedge clock);
    invalidate_valid = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    repeat (2) @(negedge clock);
    check("rst_mreq_rdy", memory_request_ready, 0);
    check("rst_dout_rdy", data_out_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_dout", data_out, 0);
    check("rst_mreq", memory_request, 0);
`ifdef ASSOC_CACHE_STATS_EN
    check("rst_hits", hit_count, 0);
    check("rst_misses", miss_count, 0);
`endif
    reset = 0;
    txn(0, 16'h000D, 0, 0, 16'h0037, 0, 0);
    txn(0, 16'h000D, 0, 1, 16'h0037, 0, 0);
    txn(1, 16'h0013, 16'h0055, 0, 0, 0, 0);
    txn(0, 16'h0013, 0, 1, 16'h0055, 0, 0);
    txn(1, 16'h0013, 16'h0066, 1, 0, 1, 0);
    txn(0, 16'h0013, 0, 1, 16'h0066, 0, 0);
    txn(0, 16'h0001, 0, 0, 16'h0101, 0, 0);
    txn(0, 16'h0009, 0, 0, 16'h0109, 0, 0);
    txn(0, 16'h0011, 0, 0, 16'h0111, 0, 0);
    txn(0, 16'h0001, 0, 0, 16'h0201, 0, 0);
    txn(0, 16'h0009, 0, 0, 16'h0209, 0, 0);
    txn(0, 16'h0001, 0, 1, 16'h0201, 0, 0);
    txn(0, 16'h0020, 0, 0, 16'h0320, 0, 0);
    inv_pulse(16'h0020);
    txn(0, 16'h0020, 0, 0, 16'h0420, 0, 0);
    inv_pulse(16'h0021);
    txn(0, 16'h0020, 0, 1, 16'h0420, 0, 0);
    txn(0, 16'h0030, 0, 0, 16'h0530, 2, 1);
    txn(0, 16'h0030, 0, 0, 16'h0630, 0, 0);
    @(negedge clock);
    memory_response = 16'h1234;
    memory_response_ready = 1;
    @(negedge clock);
    memory_response_ready = 0;
    check("stray_resp_busy", busy, 0);
    txn(0, 16'h000D, 0, 1, 16'h0037, 0, 0);
`ifdef ASSOC_CACHE_STATS_EN
    check("hits", hit_count, exp_hits);
    check("misses", miss_count, exp_misses);
`endif
    @(negedge clock);
    cpu_request = {1'b0, 16'h0, 16'h0045};
    cpu_request_ready = 1;
    k = 0;
    while (!memory_request_ready && k < 10) begin
      @(negedge clock);
      k++;
    end
    check("abort_mreq_seen", memory_request_ready, 1);
    cpu_request_ready = 0;
    reset = 1;
    #1;
    check("abort_mreq_rdy", memory_request_ready, 0);
    check("abort_dout_rdy", data_out_ready, 0);
    check("abort_busy", busy, 0);
    repeat (2) @(negedge clock);
    check("abort_no_dout", data_out_ready, 0);
    reset = 0;
    exp_hits = 0;
    exp_misses = 0;
    txn(0, 16'h000D, 0, 0, 16'h0737, 0, 0);
`ifdef ASSOC_CACHE_STATS_EN
    check("hits_after_rst", hit_count, exp_hits);
    check("misses_after_rst", miss_count, exp_misses);
`endif
    repeat (2) @(negedge clock);
    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
